spear_wave_scheduler: RTL and testbench

//  Sequences the enemy turn: on start, emits a timed stream of spear spawn requests to the enemy spear pool over a

---
 rtl/spear_wave_scheduler_pkg.sv | 51 +++++
 rtl/spear_wave_scheduler_if.sv | 32 +++
 rtl/spear_wave_scheduler_frame_lfsr.sv | 38 +++
 rtl/spear_wave_scheduler.sv | 172 +++++++++++++++++
 tb/tb_spear_wave_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spear_wave_scheduler_pkg.sv
// rtl/spear_wave_scheduler_pkg.sv - shared types, constants and difficulty clamps for the spear wave scheduler
package spear_wave_scheduler_pkg;

    localparam logic [4:0]  MAX_SPAWNS   = 5'd16;
    localparam logic [4:0]  BASE_SPAWNS  = 5'd4;
    localparam logic [7:0]  GAP_BASE     = 8'd30;
    localparam logic [7:0]  GAP_MIN      = 8'd8;
    localparam logic [7:0]  DRAIN_FRAMES = 8'd90;
    localparam logic [2:0]  SPEED_MAX    = 3'd7;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } spawn_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_OFFER,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // count = min(BASE_SPAWNS + 2*turn, MAX_SPAWNS); 6-bit intermediate so turn 15 cannot wrap
    function automatic logic [4:0] clamp_count(input logic [3:0] turn);
        logic [5:0] raw;
        raw = {1'b0, BASE_SPAWNS} + {1'b0, turn, 1'b0};
        return (raw > {1'b0, MAX_SPAWNS}) ? MAX_SPAWNS : raw[4:0];
    endfunction

    // gap = max(GAP_BASE - 2*turn, GAP_MIN); compare before subtracting so it never underflows
    function automatic logic [7:0] clamp_gap(input logic [3:0] turn);
        logic [7:0] dec;
        dec = {3'b000, turn, 1'b0};
        return ((dec + GAP_MIN) >= GAP_BASE) ? GAP_MIN : (GAP_BASE - dec);
    endfunction

    // speed = min(1 + turn/2, SPEED_MAX)
    function automatic logic [2:0] clamp_speed(input logic [3:0] turn);
        logic [3:0] raw;
        raw = 4'd1 + {1'b0, turn[3:1]};
        return (raw > {1'b0, SPEED_MAX}) ? SPEED_MAX : raw[2:0];
    endfunction

endpackage

// File: rtl/spear_wave_scheduler_if.sv
// rtl/spear_wave_scheduler_if.sv - spawn request handshake between scheduler (master) and spear pool (slave)
// Signals:
//   spawn_valid  master->slave  spawn request pending
//   spawn_ready  slave->master  pool can accept a spawn
//   spawn_dir    master->slave  approach side
//   spawn_speed  master->slave  pixels per frame
//   spawn_yellow master->slave  reversing spear flag
interface spear_wave_scheduler_if;
    import spear_wave_scheduler_pkg::*;

    logic       spawn_valid;
    logic       spawn_ready;
    spawn_dir_t spawn_dir;
    logic [2:0] spawn_speed;
    logic       spawn_yellow;

    modport master (
        output spawn_valid,
        output spawn_dir,
        output spawn_speed,
        output spawn_yellow,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_dir,
        input  spawn_speed,
        input  spawn_yellow,
        output spawn_ready
    );
endinterface

// File: rtl/spear_wave_scheduler_frame_lfsr.sv
// rtl/spear_wave_scheduler_frame_lfsr.sv - 16-bit Galois LFSR with load and step enables
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (state returns to LFSR_SEED)
//   i_load, i_seed   load i_seed (takes priority over step)
//   i_step           advance one position
//   o_dir_bits       state[1:0], raw direction candidate
//   o_yel_bits       state[7:5], yellow-spear selector
module spear_wave_scheduler_frame_lfsr
    import spear_wave_scheduler_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    input  logic        i_step,
    output logic [1:0]  o_dir_bits,
    output logic [2:0]  o_yel_bits
);
    logic [15:0] r_state;
    logic [15:0] w_shifted;
    logic [15:0] w_next;

    assign w_shifted = {1'b0, r_state[15:1]};
    assign w_next    = r_state[0] ? (w_shifted ^ LFSR_TAPS) : w_shifted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LFSR_SEED;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_dir_bits = r_state[1:0];
    assign o_yel_bits = r_state[7:5];
endmodule

// File: rtl/spear_wave_scheduler.sv
// rtl/spear_wave_scheduler.sv - enemy turn sequencer emitting frame-timed spear spawn requests
// Ports:
//   clk, rst             pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in raster position; frame tick on entering (0,0)
//   start_in             one-cycle turn start (ignored while busy)
//   abort_in             cancels the wave from any state, no finished pulse
//   turn_in              difficulty, latched on accepted start
//   spawn                master side of the spawn handshake
//   busy_out             wave in progress
//   finished_out         one-cycle pulse at wave end
// Build option: define YELLOW_SPEAR_EN to enable reversing (yellow) spears.
module spear_wave_scheduler
    import spear_wave_scheduler_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          start_in,
    input  logic                          abort_in,
    input  logic [3:0]                    turn_in,
    spear_wave_scheduler_if.master        spawn,
    output logic                          busy_out,
    output logic                          finished_out
);
`ifdef YELLOW_SPEAR_EN
    localparam bit YELLOW_EN = 1'b1;
`else
    localparam bit YELLOW_EN = 1'b0;
`endif

    sched_state_t r_state;
    sched_state_t w_next;

    logic        r_origin_d;
    logic [3:0]  r_turn;
    logic [4:0]  r_remaining;
    logic [7:0]  r_gap;
    logic [7:0]  r_cnt;
    logic [2:0]  r_speed;
    logic [1:0]  r_last1;
    logic [1:0]  r_last2;
    logic [1:0]  r_hist;

    logic        w_tick;
    logic        w_start_acc;
    logic        w_hs;
    logic        w_cnt_done;
    logic [1:0]  w_lfsr_dir;
    logic [2:0]  w_lfsr_yel;
    logic [1:0]  w_dir;
    logic        w_yellow;
    logic        w_valid;
    spawn_dir_t  w_dir_o;
    logic [2:0]  w_speed_o;
    logic        w_yellow_o;
    logic        w_busy;
    logic        w_finished;

    // Tick only on the first cycle at the raster origin, so a stalled raster yields one tick
    assign w_tick      = (hcount_in == 11'd0) && (vcount_in == 10'd0) && !r_origin_d;
    assign w_start_acc = (r_state == ST_IDLE) && start_in && !abort_in;
    assign w_hs        = (r_state == ST_OFFER) && spawn.spawn_ready && !abort_in;
    // Counter is loaded with N; the N-th tick ends the wait
    assign w_cnt_done  = w_tick && (r_cnt <= 8'd1);

    // Bump the candidate if it would make three identical directions in a row
    assign w_dir = ((r_hist == 2'd2) && (w_lfsr_dir == r_last1) && (w_lfsr_dir == r_last2))
                   ? (w_lfsr_dir + 2'd1) : w_lfsr_dir;
    assign w_yellow = YELLOW_EN && (w_lfsr_yel == 3'd0) && (r_turn >= 4'd2);

    spear_wave_scheduler_frame_lfsr u_lfsr (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_start_acc),
        .i_seed     (LFSR_SEED ^ {12'h000, turn_in}),
        .i_step     (w_hs),
        .o_dir_bits (w_lfsr_dir),
        .o_yel_bits (w_lfsr_yel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_origin_d <= 1'b0;
        end else begin
            r_origin_d <= (hcount_in == 11'd0) && (vcount_in == 10'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_turn      <= 4'd0;
            r_remaining <= 5'd0;
            r_gap       <= 8'd0;
            r_cnt       <= 8'd0;
            r_speed     <= 3'd0;
            r_last1     <= 2'd0;
            r_last2     <= 2'd0;
            r_hist      <= 2'd0;
        end else if (w_start_acc) begin
            r_turn      <= turn_in;
            r_remaining <= clamp_count(turn_in);
            r_gap       <= clamp_gap(turn_in);
            r_speed     <= clamp_speed(turn_in);
            r_hist      <= 2'd0;
        end else if (w_hs) begin
            r_remaining <= r_remaining - 5'd1;
            r_cnt       <= (r_remaining == 5'd1) ? DRAIN_FRAMES : r_gap;
            r_last2     <= r_last1;
            r_last1     <= w_dir;
            r_hist      <= (r_hist == 2'd2) ? 2'd2 : (r_hist + 2'd1);
        end else if (((r_state == ST_GAP) || (r_state == ST_DRAIN)) && w_tick && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_valid    = 1'b0;
        w_dir_o    = DIR_UP;
        w_speed_o  = 3'd0;
        w_yellow_o = 1'b0;
        w_busy     = 1'b0;
        w_finished = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) w_next = ST_ARM;
            end
            ST_ARM: begin
                w_busy = 1'b1;
                if (w_tick) w_next = ST_OFFER;
            end
            ST_OFFER: begin
                w_busy     = 1'b1;
                w_valid    = 1'b1;
                w_dir_o    = spawn_dir_t'(w_dir);
                w_speed_o  = r_speed;
                w_yellow_o = w_yellow;
                if (w_hs) w_next = (r_remaining == 5'd1) ? ST_DRAIN : ST_GAP;
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (w_cnt_done) w_next = ST_OFFER;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_cnt_done) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_finished = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort_in) w_next = ST_IDLE;
    end

    assign spawn.spawn_valid  = w_valid;
    assign spawn.spawn_dir    = w_dir_o;
    assign spawn.spawn_speed  = w_speed_o;
    assign spawn.spawn_yellow = w_yellow_o;
    assign busy_out           = w_busy;
    assign finished_out       = w_finished;
endmodule

// File: tb/tb_spear_wave_scheduler.sv
// tb/tb_spear_wave_scheduler.sv - randomized self-checking bench for spear_wave_scheduler
module tb_spear_wave_scheduler;
    import spear_wave_scheduler_pkg::*;

    localparam int H_TOTAL = 6;
    localparam int V_TOTAL = 4;
`ifdef YELLOW_SPEAR_EN
    localparam bit TB_YEL = 1'b1;
`else
    localparam bit TB_YEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [3:0]  turn_in = 4'd0;
    logic        busy_out;
    logic        finished_out;
    int          ready_mode = 0;

    spear_wave_scheduler_if u_if ();

    spear_wave_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .start_in     (start_in),
        .abort_in     (abort_in),
        .turn_in      (turn_in),
        .spawn        (u_if),
        .busy_out     (busy_out),
        .finished_out (finished_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Raster with random stalls (a stall at the origin must still give a single tick) and ready policy
    initial begin
        u_if.spawn_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 7) != 0) begin
                if (hcount == 11'(H_TOTAL - 1)) begin
                    hcount = 11'd0;
                    vcount = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount = hcount + 11'd1;
                end
            end
            case (ready_mode)
                0:       u_if.spawn_ready = 1'b1;
                1:       u_if.spawn_ready = ($urandom_range(0, 3) != 0);
                default: u_if.spawn_ready = 1'b0;
            endcase
        end
    end

    // Reference model: whole wave precomputed from turn number at start
    bit         m_busy;
    int         m_count, m_gap, m_speed, m_hs, m_ticks, m_exp_ticks;
    logic [1:0] m_dir [16];
    bit         m_yel [16];
    bit         prev_origin, prev_tick, prev_valid, prev_ready, prev_abort;
    logic [1:0] prev_dir, obs_last1, obs_last2;
    logic [2:0] prev_speed;
    logic       prev_yel;
    int         obs_n;
    bit         chk_busy_next, chk_abort_next;
    int         fin_cnt = 0;
    int         hs_total = 0;
    bit         origin_now, tick_now, busy_before;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic build_model(input int t);
        logic [15:0] s;
        logic [1:0]  cand;
        m_count = (4 + 2 * t > 16) ? 16 : 4 + 2 * t;
        m_gap   = (30 - 2 * t < 8) ? 8 : 30 - 2 * t;
        m_speed = (1 + t / 2 > 7) ? 7 : 1 + t / 2;
        s = 16'hACE1 ^ 16'(t);
        for (int i = 0; i < m_count; i++) begin
            cand = s[1:0];
            if (i >= 2 && cand == m_dir[i-1] && cand == m_dir[i-2]) cand = cand + 2'd1;
            m_dir[i] = cand;
            m_yel[i] = TB_YEL && (s[7:5] == 3'd0) && (t >= 2);
            s = lfsr_next(s);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_hs = 0; m_ticks = 0; m_exp_ticks = 0; obs_n = 0;
            prev_origin = 0; prev_tick = 0; prev_valid = 0; prev_ready = 0; prev_abort = 0;
            chk_busy_next = 0; chk_abort_next = 0;
        end else begin
            origin_now  = (hcount == 11'd0) && (vcount == 10'd0);
            tick_now    = origin_now && !prev_origin;
            busy_before = m_busy;
            if (chk_busy_next) begin
                check("busy_after_start", 32'(busy_out), 1);
                chk_busy_next = 0;
            end
            if (chk_abort_next) begin
                check("abort_busy", 32'(busy_out), 0);
                check("abort_valid", 32'(u_if.spawn_valid), 0);
                chk_abort_next = 0;
            end
            if (u_if.spawn_valid && !prev_valid) begin
                check("offer_busy", 32'(busy_out), 1);
                check("offer_ticks", 32'(m_ticks), 32'(m_exp_ticks));
                check("offer_after_tick", 32'(prev_tick), 1);
            end
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("hold_valid", 32'(u_if.spawn_valid), 1);
                check("hold_dir", 32'(u_if.spawn_dir), 32'(prev_dir));
                check("hold_speed", 32'(u_if.spawn_speed), 32'(prev_speed));
                check("hold_yellow", 32'(u_if.spawn_yellow), 32'(prev_yel));
            end
            if (finished_out) begin
                fin_cnt++;
                check("fin_expected", 32'(m_busy), 1);
                check("fin_ticks", 32'(m_ticks), 90);
                check("fin_after_tick", 32'(prev_tick), 1);
                check("fin_count", 32'(m_hs), 32'(m_count));
                check("fin_busy", 32'(busy_out), 0);
                m_busy = 0;
            end
            if (u_if.spawn_valid && u_if.spawn_ready && !abort_in) begin
                check("hs_in_wave", 32'(m_busy && m_hs < m_count), 1);
                if (m_busy && m_hs < m_count) begin
                    check("hs_dir", 32'(u_if.spawn_dir), 32'(m_dir[m_hs]));
                    check("hs_speed", 32'(u_if.spawn_speed), 32'(m_speed));
                    check("hs_yellow", 32'(u_if.spawn_yellow), 32'(m_yel[m_hs]));
                end
                if (obs_n >= 2)
                    check("no_triple", 32'(u_if.spawn_dir == obs_last1 && u_if.spawn_dir == obs_last2), 0);
                obs_last2 = obs_last1;
                obs_last1 = u_if.spawn_dir;
                obs_n++;
                m_hs++;
                hs_total++;
                m_ticks = 0;
                m_exp_ticks = m_gap;
            end else if (!u_if.spawn_valid && tick_now) begin
                m_ticks++;
            end
            if (start_in && !abort_in && !busy_before) begin
                build_model(int'(turn_in));
                m_busy = 1; m_hs = 0; m_ticks = 0; m_exp_ticks = 1; obs_n = 0;
                chk_busy_next = 1;
            end
            if (abort_in) begin
                m_busy = 0;
                chk_abort_next = 1;
            end
            prev_origin = origin_now;
            prev_tick   = tick_now;
            prev_valid  = u_if.spawn_valid;
            prev_ready  = u_if.spawn_ready;
            prev_abort  = abort_in;
            prev_dir    = u_if.spawn_dir;
            prev_speed  = u_if.spawn_speed;
            prev_yel    = u_if.spawn_yellow;
        end
    end

    task automatic pulse_start(input int t);
        @(posedge clk); #1;
        turn_in  = 4'(t);
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1;
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int f0;
        int k;
        f0 = fin_cnt;
        k = 0;
        while (fin_cnt == f0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(fin_cnt != f0), 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!u_if.spawn_valid && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(u_if.spawn_valid), 1);
    endtask

    task automatic wait_hs(input string tag, input int n);
        int h0;
        int k;
        h0 = hs_total;
        k = 0;
        while (hs_total < h0 + n && k < 10000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(hs_total >= h0 + n), 1);
    endtask

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(u_if.spawn_valid), 0);
        check("reset_busy", 32'(busy_out), 0);
        check("reset_finished", 32'(finished_out), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset asserted while a spawn is being offered
        ready_mode = 2;
        pulse_start(2);
        wait_valid("t1_offer");
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(u_if.spawn_valid), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_finished", 32'(finished_out), 0);
        check("rst_dir", 32'(u_if.spawn_dir), 0);
        check("rst_speed", 32'(u_if.spawn_speed), 0);
        check("rst_yellow", 32'(u_if.spawn_yellow), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_mode = 0;

        // Turn 0, ready held high
        pulse_start(0);
        wait_finish("t2_finish");

        // Abort in GAP
        ready_mode = 1;
        pulse_start(4);
        wait_hs("t5_hs", 2);
        repeat (5) @(posedge clk);
        pulse_abort();
        f0 = fin_cnt;
        repeat (300) @(posedge clk);
        check("abort_no_finish", 32'(fin_cnt), 32'(f0));

        // Turn 15 with a stray start mid-wave
        pulse_start(15);
        repeat (200) @(posedge clk);
        pulse_start(0);
        wait_finish("t3_finish");

        // Long back-pressure on the first offer
        ready_mode = 2;
        pulse_start(3);
        wait_valid("t4_offer");
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("t4_still_valid", 32'(u_if.spawn_valid), 1);
        ready_mode = 0;
        wait_finish("t4_finish");

        ready_mode = 1;
        pulse_start(1);
        wait_finish("t6_finish");

        repeat (2) begin
            pulse_start(int'($urandom_range(0, 15)));
            wait_finish("rand_finish");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
